// File: rtl/eu_mem_responder_pkg.sv
// ============================================================================
// eu_mem_responder_pkg : shared constants and FSM encoding for the EU memory port
// Revision: 1.0
// ============================================================================
`default_nettype none

package eu_mem_responder_pkg;

    localparam int DW     = 8;
    localparam int AW     = 5;
    localparam int DEPTH  = 32;
    localparam int RDEPTH = 2;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/eu_mem_responder_resp_fifo.sv
// ============================================================================
// eu_mem_responder_resp_fifo : in-order read-response FIFO with held output word
// Revision: 1.0
// ============================================================================
`default_nettype none

module eu_mem_responder_resp_fifo
    import eu_mem_responder_pkg::*;
#(
    parameter int FIFO_DW    = DW,
    parameter int FIFO_DEPTH = RDEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [FIFO_DW-1:0] data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [FIFO_DW-1:0] head_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_DW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      cnt_q;
    logic [FIFO_DW-1:0] last_q;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    // Once drained, the output keeps showing the most recently popped word.
    assign head_o  = empty_o ? last_q : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= ptr_next(wr_q);
            end
            if (pop_i) begin
                rd_q   <= ptr_next(rd_q);
                last_q <= mem_q[rd_q];
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_i && !push_i) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

`default_nettype wire

// File: rtl/eu_mem_responder.sv
// ============================================================================
// eu_mem_responder : 32x8 operand store with INIT sweep and buffered read responses
// Revision: 1.0
// ============================================================================
`default_nettype none

module eu_mem_responder
    import eu_mem_responder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          init_done
);

    logic [DW-1:0] store_q [DEPTH];
    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic w_full, w_empty, w_accept, w_push, w_pop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ready depends only on registered state, never on resp_ready.
    assign req_ready = (state_q == ST_RUN) && !w_full;
    assign init_done = (state_q == ST_RUN);
    assign w_accept  = req_valid && req_ready;
    assign w_push    = w_accept && !req_write;
    assign resp_valid = !w_empty;
    assign w_pop     = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            store_q[cnt_q] <= '0;
        end else if (w_accept && req_write) begin
            store_q[req_addr] <= req_wdata;
        end
    end

    eu_mem_responder_resp_fifo #(
        .FIFO_DW    (DW),
        .FIFO_DEPTH (RDEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (store_q[req_addr]),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (resp_data)
    );

endmodule

`default_nettype wire
